// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-addressed memory between the instruction
// fetch port and the load/store data port of the three-stage core.
//
// Each cycle at most one request is granted, and the grant is combinational
// from the current requests. An accepted in-range request drives the memory
// strobes in the same cycle. The read word, or an error/write acknowledge, is
// returned to the owning port one cycle later. Out-of-range addresses never
// reach the memory. Instead they are answered with err=1 and rdata=0.
//
// Configuration macro: MEM_ARB_STARVE_EN
//   defined   - a saturating starvation counter forces fetch ahead of data
//               once fetch has been denied STARVE_LIMIT consecutive cycles.
//   undefined - strict data-over-fetch priority, with no counter.
//
// Request/response handshake (both ports):
//   The requester raises req and holds req and all of its fields stable until
//   it sees ready=1 in the same cycle. Ready may be 1 in the very cycle that
//   req rises, and ready=1 means the request is consumed at that clock edge.
//   A requester that drops req before it sees ready gets no response.
//   Every accepted request produces exactly one valid pulse on its own port
//   in the following cycle, for reads and writes alike. There is no
//   backpressure on responses. err qualifies valid, and rdata is 0 for
//   writes and errors.

module mem_arbiter #(
  parameter int MEMSIZE      = 131072,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_rdata,
  output logic        inst_err,

  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wbe,
  output logic        data_ready,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic        data_err,

  output logic        mem_read_ready,
  output logic        mem_write_ready,
  output logic [29:0] mem_read_address,
  output logic [29:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_byte,
  input  logic [31:0] mem_read_data
);

  // Number of byte-address bits that fall inside the memory.
  localparam int AW = $clog2(MEMSIZE);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  // Address range decode. Bits above the memory size must all be zero.
  logic inst_in_range;
  logic data_in_range;

  assign inst_in_range = (inst_addr[31:AW] == '0);
  assign data_in_range = (data_addr[31:AW] == '0);

  // The two byte-offset bits are ignored because the memory is word addressed.
  logic unused_byte_offset;
  assign unused_byte_offset = ^{inst_addr[1:0], data_addr[1:0]};

  // When set, this signal lets fetch win over data for one cycle.
  logic starve_force;

`ifdef MEM_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;

  // Count consecutive cycles in which fetch is pending but not granted.
  // The count saturates at STARVE_LIMIT and clears once fetch is served or
  // withdrawn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!inst_req || inst_ready) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign starve_force = inst_req && (starve_cnt == CW'(STARVE_LIMIT));
`else
  // Strict data priority applies, so fetch is never forced ahead.
  logic unused_starve_cfg;
  assign unused_starve_cfg = (STARVE_LIMIT > 0);
  assign starve_force      = 1'b0;
`endif

  // Grant logic: data wins unless the starvation override is active.
  // The two grants are mutually exclusive by construction.
  logic inst_gnt;
  logic data_gnt;

  // Decide which single request is accepted this cycle.
  always_comb begin
    data_gnt = data_req && !starve_force;
    inst_gnt = inst_req && !data_gnt;
  end

  assign inst_ready = inst_gnt;
  assign data_ready = data_gnt;

  // Drive the memory strobes and buses for the granted in-range request.
  // The buses are held at 0 whenever no strobe is active.
  always_comb begin
    mem_read_ready    = 1'b0;
    mem_write_ready   = 1'b0;
    mem_read_address  = '0;
    mem_write_address = '0;
    mem_write_data    = '0;
    mem_write_byte    = '0;
    if (data_gnt && data_in_range) begin
      if (data_we) begin
        mem_write_ready   = 1'b1;
        mem_write_address = data_addr[31:2];
        mem_write_data    = data_wdata;
        mem_write_byte    = data_wbe;
      end else begin
        mem_read_ready    = 1'b1;
        mem_read_address  = data_addr[31:2];
      end
    end else if (inst_gnt && inst_in_range) begin
      mem_read_ready   = 1'b1;
      mem_read_address = inst_addr[31:2];
    end
  end

  // Response register: records who was served, and whether the request was a
  // write or an error, so the next cycle can route mem_read_data correctly.
  owner_t resp_owner;
  logic   resp_write;
  logic   resp_err;

  // Capture the accepted request's owner, kind and error flag.
  // Reset drops any pending response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_owner <= OWN_NONE;
      resp_write <= 1'b0;
      resp_err   <= 1'b0;
    end else if (data_gnt) begin
      resp_owner <= OWN_DATA;
      resp_write <= data_we;
      resp_err   <= !data_in_range;
    end else if (inst_gnt) begin
      resp_owner <= OWN_INST;
      resp_write <= 1'b0;
      resp_err   <= !inst_in_range;
    end else begin
      resp_owner <= OWN_NONE;
      resp_write <= 1'b0;
      resp_err   <= 1'b0;
    end
  end

  // True when the returned memory word is meaningful for the recorded owner.
  logic resp_has_data;
  assign resp_has_data = !resp_write && !resp_err;

  // Steer the response to its owner. The other port sees all zeros.
  always_comb begin
    inst_valid = 1'b0;
    inst_rdata = '0;
    inst_err   = 1'b0;
    data_valid = 1'b0;
    data_rdata = '0;
    data_err   = 1'b0;
    case (resp_owner)
      OWN_INST: begin
        inst_valid = 1'b1;
        inst_err   = resp_err;
        inst_rdata = resp_has_data ? mem_read_data : '0;
      end
      OWN_DATA: begin
        data_valid = 1'b1;
        data_err   = resp_err;
        data_rdata = resp_has_data ? mem_read_data : '0;
      end
      default: ;
    endcase
  end

endmodule
